// File: rtl/osc_acq_if.sv
// Command/status bundle between the scope register bank and osc_acq_seq.
// The auto_i field exists only when ACQ_AUTO_REARM_EN is defined.
interface osc_acq_if #(
   parameter int CW = 32,
   parameter int AW = 14,
   parameter int DW = 17,
   parameter int NT = 15
);
   logic          arm_i;
   logic          acq_rst_i;
   logic [3:0]    trig_src_i;
   logic [NT-1:0] trig_vec_i;
   logic [CW-1:0] pre_len_i;
   logic [CW-1:0] post_len_i;
   logic [DW-1:0] dec_i;
`ifdef ACQ_AUTO_REARM_EN
   logic          auto_i;
`endif
   logic          smp_we_o;
   logic [AW-1:0] wr_ptr_o;
   logic [AW-1:0] trig_ptr_o;
   logic          armed_o;
   logic          trig_o;
   logic          busy_o;
   logic          done_o;
   logic [3:0]    src_act_o;

   modport master (
`ifdef ACQ_AUTO_REARM_EN
      output auto_i,
`endif
      output arm_i, acq_rst_i, trig_src_i, trig_vec_i,
      output pre_len_i, post_len_i, dec_i,
      input  smp_we_o, wr_ptr_o, trig_ptr_o, armed_o,
      input  trig_o, busy_o, done_o, src_act_o
   );

   modport slave (
`ifdef ACQ_AUTO_REARM_EN
      input  auto_i,
`endif
      input  arm_i, acq_rst_i, trig_src_i, trig_vec_i,
      input  pre_len_i, post_len_i, dec_i,
      output smp_we_o, wr_ptr_o, trig_ptr_o, armed_o,
      output trig_o, busy_o, done_o, src_act_o
   );
endinterface

// File: rtl/osc_acq_seq.sv
// Scope acquisition sequencer: decimation, circular write pointer, pre/trig/post FSM.
// Optional auto re-arm from DONE is enabled by defining ACQ_AUTO_REARM_EN.
module osc_acq_seq #(
   parameter int CW = 32,
   parameter int AW = 14,
   parameter int DW = 17,
   parameter int NT = 15
) (
   input logic      adc_clk_i,
   input logic      adc_rstn_i,
   osc_acq_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE
   } st_e;

   st_e           st_q;
   logic [DW-1:0] dec_cnt_q;
   logic [CW-1:0] pre_cnt_q;
   logic [CW-1:0] post_cnt_q;
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] trig_ptr_q;
   logic [3:0]    src_act_q;
   logic          smp_we_q;
   logic          trig_q;
   logic          done_q;

   logic          dec_stb;
   logic          rearm;
   logic          start;
   logic          post_end;
   logic          trig_hit;
   logic          we_d;
   logic [NT:0]   tv_ext;

   // bit 0 is tied low so source code 0 can never fire
   assign tv_ext   = {bus.trig_vec_i, 1'b0};
   assign dec_stb  = (bus.dec_i <= DW'(1)) ||
                     (dec_cnt_q == bus.dec_i - DW'(1));
   assign post_end = (post_cnt_q == bus.post_len_i);
   assign trig_hit = (st_q == S_WAIT) && tv_ext[src_act_q];

`ifdef ACQ_AUTO_REARM_EN
   assign rearm = (st_q == S_DONE) && bus.auto_i;
`else
   assign rearm = 1'b0;
`endif

   assign start = rearm || (bus.arm_i &&
                  ((st_q == S_IDLE) || (st_q == S_DONE)));

   // the closing POST cycle (count reached) writes nothing
   assign we_d = dec_stb && ((st_q == S_PRE) || (st_q == S_WAIT) ||
                 ((st_q == S_POST) && !post_end));

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         st_q       <= S_IDLE;
         dec_cnt_q  <= '0;
         pre_cnt_q  <= '0;
         post_cnt_q <= '0;
         wr_ptr_q   <= '0;
         trig_ptr_q <= '0;
         src_act_q  <= '0;
         smp_we_q   <= 1'b0;
         trig_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         trig_q    <= 1'b0;
         done_q    <= 1'b0;
         smp_we_q  <= we_d;
         dec_cnt_q <= dec_stb ? '0 : dec_cnt_q + DW'(1);
         if (smp_we_q) wr_ptr_q <= wr_ptr_q + AW'(1);

         if (bus.acq_rst_i) begin
            st_q       <= S_IDLE;
            smp_we_q   <= 1'b0;
            wr_ptr_q   <= '0;
            dec_cnt_q  <= '0;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
            src_act_q  <= '0;
         end else if (start) begin
            st_q       <= S_PRE;
            src_act_q  <= bus.trig_src_i;
            dec_cnt_q  <= '0;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
         end else begin
            case (st_q)
               S_PRE: begin
                  if (dec_stb && (pre_cnt_q < bus.pre_len_i))
                     pre_cnt_q <= pre_cnt_q + CW'(1);
                  if (pre_cnt_q >= bus.pre_len_i)
                     st_q <= S_WAIT;
               end
               S_WAIT: begin
                  // pending write lands at wr_ptr+1, so that is the trigger sample
                  if (trig_hit) begin
                     st_q       <= S_POST;
                     trig_q     <= 1'b1;
                     trig_ptr_q <= wr_ptr_q + AW'(smp_we_q);
                     src_act_q  <= '0;
                  end
               end
               S_POST: begin
                  if (post_end) begin
                     st_q   <= S_DONE;
                     done_q <= 1'b1;
                  end else if (dec_stb) begin
                     post_cnt_q <= post_cnt_q + CW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.smp_we_o   = smp_we_q;
   assign bus.wr_ptr_o   = wr_ptr_q;
   assign bus.trig_ptr_o = trig_ptr_q;
   assign bus.trig_o     = trig_q;
   assign bus.done_o     = done_q;
   assign bus.src_act_o  = src_act_q;
   assign bus.armed_o    = (st_q == S_PRE) || (st_q == S_WAIT);
   assign bus.busy_o     = (st_q == S_PRE) || (st_q == S_WAIT) ||
                           (st_q == S_POST);

endmodule

// File: tb/tb_osc_acq_seq.sv
// Randomized bench for osc_acq_seq; expectations come from closed-form timing.
// Auto re-arm scenario is built only with ACQ_AUTO_REARM_EN.
module tb_osc_acq_seq;
   localparam int CW = 32;
   localparam int AW = 14;
   localparam int DW = 17;
   localparam int NT = 15;
   localparam int NEVER = 1 << 26;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   int   ptr_m = 0;
   logic [AW-1:0] tptr_m = '0;

   always #5 clk = ~clk;

   osc_acq_if #(.CW(CW), .AW(AW), .DW(DW), .NT(NT)) bus ();

   osc_acq_seq #(.CW(CW), .AW(AW), .DW(DW), .NT(NT)) dut (
      .adc_clk_i (clk),
      .adc_rstn_i(rst_n),
      .bus       (bus)
   );

   task automatic drive_idle();
      bus.arm_i      = 1'b0;
      bus.acq_rst_i  = 1'b0;
      bus.trig_vec_i = '0;
`ifdef ACQ_AUTO_REARM_EN
      bus.auto_i     = 1'b0;
`endif
   endtask

   task automatic test_reset();
      logic [44:0] o;
      bus.trig_src_i = 4'd3;
      bus.pre_len_i  = 32'd2;
      bus.post_len_i = 32'd2;
      bus.dec_i      = 17'd1;
      bus.arm_i      = 1'b1;
      bus.acq_rst_i  = 1'b0;
      bus.trig_vec_i = '1;
`ifdef ACQ_AUTO_REARM_EN
      bus.auto_i     = 1'b1;
`endif
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         o = {bus.smp_we_o, bus.wr_ptr_o, bus.trig_ptr_o,
              bus.armed_o, bus.trig_o, bus.busy_o,
              bus.done_o, bus.src_act_o};
         n_vec++;
         if (o !== '0) begin
            n_err++;
            $display("FAIL reset_outs cyc=%0d got=%h exp=0", k, o);
         end
      end
      drive_idle();
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (bus.busy_o !== 1'b0 || bus.wr_ptr_o !== '0) begin
         n_err++;
         $display("FAIL reset_idle got busy=%b ptr=%0d exp 0/0",
                  bus.busy_o, bus.wr_ptr_o);
      end
   endtask

   // Arm at cycle 0; trigger (selected source) at WAIT start + toff.
   // Ticks fall on multiples of D; a tick at t is written at t+1.
   // Everything up to the post-th tick after the trigger is written.
   task automatic run_acq(input int d, input int p, input int post,
                          input int src, input int toff,
                          input int rst_at);
      int dd, w, c, l, last, am, m, cnt, tmp, nw, lim;
      logic pr, ew, et, edn, ear, ebz;
      logic [3:0] es;
      logic [AW-1:0] ep, etp;
      logic [NT-1:0] sel, tv;
      int r32;
      dd = (d <= 1) ? 1 : d;
      w = dd * p + 2;
      c = (src == 0) ? NEVER : w + toff;
      if (post == 0) l = c;
      else l = (c / dd + 1) * dd + (post - 1) * dd;
      last = (rst_at >= 0) ? rst_at + 3 : l + 5;
      lim = (rst_at >= 0) ? rst_at : l + 1;
      am = $urandom_range(lim, 1);
      sel = '0;
      if (src != 0) sel[src-1] = 1'b1;
      tmp = d;
      bus.dec_i = tmp[DW-1:0];
      bus.pre_len_i = p;
      bus.post_len_i = post;
      tmp = src;
      bus.trig_src_i = tmp[3:0];
      nw = 0;
      for (int i = 0; i <= last; i++) begin
         @(negedge clk);
         pr = (rst_at >= 0) && (i > rst_at);
         ew = !pr && (i - 1 >= dd) && ((i - 1) % dd == 0) && (i - 1 <= l);
         m = (i - 2 < l) ? i - 2 : l;
         cnt = (m >= dd) ? m / dd : 0;
         tmp = pr ? 0 : ptr_m + cnt;
         ep = tmp[AW-1:0];
         et = !pr && (i == c + 1);
         edn = !pr && (i == l + 2);
         ear = !pr && (i >= 1) && (i <= c);
         ebz = !pr && (i >= 1) && (i <= l + 1);
         tmp = src;
         es = ear ? tmp[3:0] : 4'd0;
         tmp = ptr_m + (c - 1) / dd;
         etp = (i >= c + 1) ? tmp[AW-1:0] : tptr_m;
         if (bus.smp_we_o === 1'b1) nw++;

         n_vec++;
         if (bus.smp_we_o !== ew) begin
            n_err++;
            $display("FAIL smp_we cyc=%0d got=%b exp=%b", i, bus.smp_we_o, ew);
         end
         n_vec++;
         if (bus.wr_ptr_o !== ep) begin
            n_err++;
            $display("FAIL wr_ptr cyc=%0d got=%0d exp=%0d", i, bus.wr_ptr_o, ep);
         end
         n_vec++;
         if (bus.trig_o !== et) begin
            n_err++;
            $display("FAIL trig_o cyc=%0d got=%b exp=%b", i, bus.trig_o, et);
         end
         n_vec++;
         if (bus.done_o !== edn) begin
            n_err++;
            $display("FAIL done_o cyc=%0d got=%b exp=%b", i, bus.done_o, edn);
         end
         n_vec++;
         if (bus.armed_o !== ear || bus.busy_o !== ebz) begin
            n_err++;
            $display("FAIL armed_busy cyc=%0d got=%b%b exp=%b%b", i,
                     bus.armed_o, bus.busy_o, ear, ebz);
         end
         n_vec++;
         if (bus.src_act_o !== es) begin
            n_err++;
            $display("FAIL src_act cyc=%0d got=%0d exp=%0d", i, bus.src_act_o, es);
         end
         if (!pr) begin
            n_vec++;
            if (bus.trig_ptr_o !== etp) begin
               n_err++;
               $display("FAIL trig_ptr cyc=%0d got=%0d exp=%0d", i,
                        bus.trig_ptr_o, etp);
            end
         end

         r32 = $urandom;
         tv = r32[NT-1:0];
         if (src != 0) begin
            tv = tv & ~sel;
            if (i == c || (i < w && (i == w - 1 || i == 6 || r32[20])))
               tv = tv | sel;
         end
         if (i == rst_at) tv = '1;
         bus.trig_vec_i = tv;
         bus.arm_i = (i == 0) || (i == am) || (i == rst_at);
         bus.acq_rst_i = (i == rst_at);
      end
      drive_idle();
      if (rst_at < 0) begin
         n_vec++;
         if (nw != l / dd) begin
            n_err++;
            $display("FAIL total_writes got=%0d exp=%0d", nw, l / dd);
         end
      end
      if (rst_at < 0 || c < rst_at) begin
         tmp = ptr_m + (c - 1) / dd;
         tptr_m = tmp[AW-1:0];
      end
      ptr_m = (rst_at >= 0) ? 0 : (ptr_m + l / dd) % (1 << AW);
   endtask

   task automatic test_basic();
      run_acq(1, 10, 5, 3, 4, -1);
   endtask

   task automatic test_decim();
      run_acq(4, 3, 2, 7, 2, -1);
      run_acq(0, 5, 3, 12, 1, -1);
      run_acq(1, 5, 3, 12, 1, -1);
   endtask

   task automatic test_post0();
      run_acq(1, 4, 0, 9, 3, -1);
      run_acq(3, 2, 0, 2, 1, -1);
   endtask

   task automatic test_acq_rst();
      run_acq(2, 2, 3, 6, 1, 7);
      run_acq(1, 3, 6, 4, 2, 14);
   endtask

   task automatic test_wrap();
      run_acq(1, (1 << AW) - 5, 0, 1, 0, -1);
      run_acq(1, 2, 2, 1, 0, -1);
   endtask

   task automatic test_no_src();
      run_acq(2, 3, 4, 0, 0, 40);
   endtask

   task automatic test_random();
      int d, p, post, src, toff;
      for (int k = 0; k < 12; k++) begin
         d = $urandom_range(5, 0);
         p = $urandom_range(12, 0);
         post = $urandom_range(8, 0);
         src = $urandom_range(NT, 1);
         toff = $urandom_range(3 * ((d <= 1) ? 1 : d), 0);
         run_acq(d, p, post, src, toff, -1);
      end
   endtask

`ifdef ACQ_AUTO_REARM_EN
   task automatic test_auto();
      int ndone, ntrig, tmp;
      logic [AW-1:0] etp;
      logic et, edn;
      ndone = 0;
      ntrig = 0;
      bus.dec_i = 17'd1;
      bus.pre_len_i = 32'd2;
      bus.post_len_i = 32'd2;
      bus.trig_src_i = 4'd5;
      for (int i = 0; i <= 26; i++) begin
         @(negedge clk);
         et = (i == 5) || (i == 13) || (i == 21);
         edn = (i == 8) || (i == 16) || (i == 24);
         if (bus.done_o === 1'b1) ndone++;
         n_vec++;
         if (bus.trig_o !== et || bus.done_o !== edn) begin
            n_err++;
            $display("FAIL auto_pulses cyc=%0d got=%b%b exp=%b%b", i,
                     bus.trig_o, bus.done_o, et, edn);
         end
         if (et) begin
            tmp = ptr_m + 3 + 6 * ntrig;
            etp = tmp[AW-1:0];
            ntrig++;
            n_vec++;
            if (bus.trig_ptr_o !== etp) begin
               n_err++;
               $display("FAIL auto_trig_ptr cyc=%0d got=%0d exp=%0d", i,
                        bus.trig_ptr_o, etp);
            end
         end
         if (i == 9 || i == 17) begin
            n_vec++;
            if (bus.armed_o !== 1'b1 || bus.src_act_o !== 4'd5) begin
               n_err++;
               $display("FAIL auto_rearm cyc=%0d got=%b/%0d exp=1/5", i,
                        bus.armed_o, bus.src_act_o);
            end
         end
         bus.trig_vec_i = 15'h0010;
         bus.arm_i = (i == 0);
         bus.auto_i = (i < 24);
      end
      n_vec++;
      if (ndone != 3) begin
         n_err++;
         $display("FAIL auto_done_count got=%0d exp=3", ndone);
      end
      drive_idle();
      bus.acq_rst_i = 1'b1;
      @(negedge clk);
      drive_idle();
      ptr_m = 0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_decim();
      test_post0();
      test_acq_rst();
      test_wrap();
      test_no_src();
      test_random();
`ifdef ACQ_AUTO_REARM_EN
      test_auto();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
